seven_seg_scanner: RTL

Parametrised multiplexed seven-segment display driver: latches a hex value and per-digit decimal points from the CPU bus and scans them across `DIGITS` common-select displays. It generalises the fixed six-digit output stage with configurable digit count, per-digit decimal points, optional leading-zero blanking, an inter-digit blanking slot against ghosting, and selectable output polarity. It sits at the board edge, fed by the CPU bus and driving the segment and select pins.

---
 rtl/seven_seg_pkg.sv | 51 +++++
 rtl/scan_divider.sv | 34 +++
 rtl/seven_seg_scanner.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scanner: glyph table, scan states, hex decoder.
// Purely combinational helpers with no latency and no backpressure.
package seven_seg_pkg;

  typedef enum logic {
    ST_DRIVE = 1'b0,
    ST_BLANK = 1'b1
  } scan_state_t;

  // Glyphs use bit 6 = segment a down to bit 0 = segment g, logical-active high.
  localparam logic [6:0] GLYPH_0 = 7'h7E;
  localparam logic [6:0] GLYPH_1 = 7'h30;
  localparam logic [6:0] GLYPH_2 = 7'h6D;
  localparam logic [6:0] GLYPH_3 = 7'h79;
  localparam logic [6:0] GLYPH_4 = 7'h33;
  localparam logic [6:0] GLYPH_5 = 7'h5B;
  localparam logic [6:0] GLYPH_6 = 7'h5F;
  localparam logic [6:0] GLYPH_7 = 7'h70;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h7B;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h1F;
  localparam logic [6:0] GLYPH_C = 7'h4E;
  localparam logic [6:0] GLYPH_D = 7'h3D;
  localparam logic [6:0] GLYPH_E = 7'h4F;
  localparam logic [6:0] GLYPH_F = 7'h47;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      default: seg = GLYPH_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/scan_divider.sv
// Slot divider: counts 0..DIVISOR-1 and flags the last count as a one-cycle tick.
// Tick is decoded from the count register (no extra latency); free-running, no backpressure.
module scan_divider #(
  parameter int unsigned DIVISOR = 32'hFFFF
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] count;
  logic          run;

  // run keeps tick low while reset is held, which matters when DIVISOR is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  assign tick = run & (count == LAST);

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment driver: latches a hex value plus decimal points and scans them across DIGITS displays.
// Pins are registered (1 clock behind state/load); no backpressure, loads accepted on every clock.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int          DATA_WIDTH     = 8,
  parameter int          DIGITS         = 6,
  parameter int unsigned SCAN_DIVISOR   = 32'hFFFF,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  i_SYS_CLOCK,
  input  logic                  i_CLEAR_n,
  input  logic [DATA_WIDTH-1:0] i_BUS,
  input  logic                  i_READ_BUS,
  input  logic [DIGITS-1:0]     i_DP,
  input  logic                  i_BLANK_LZ,
  output logic [6:0]            o_SEG,
  output logic                  o_SEG_DP,
  output logic [DIGITS-1:0]     o_SEL,
  output logic                  o_SCAN_TICK
);

  localparam int VW    = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  localparam logic [DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = SEG_ACTIVE_LOW;

  logic [VW-1:0]     bus_ext;
  logic [VW-1:0]     value;
  logic [DIGITS-1:0] dp_reg;
  logic              scan_tick;

  scan_state_t       state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;

  logic [DIGITS-1:0] lz_mask;
  logic              zero_above;

  logic [DIGITS-1:0] sel_hot;
  logic [3:0]        nibble;
  logic              digit_dp;
  logic              digit_lz;
  logic [DIGITS-1:0] sel_on;
  logic [6:0]        seg_on;
  logic              dp_on;

  generate
    if (DATA_WIDTH >= VW) begin : g_bus_trunc
      assign bus_ext = i_BUS[VW-1:0];
    end else begin : g_bus_ext
      assign bus_ext = {{(VW - DATA_WIDTH){1'b0}}, i_BUS};
    end
  endgenerate

  always_ff @(posedge i_SYS_CLOCK or negedge i_CLEAR_n) begin
    if (!i_CLEAR_n) begin
      value  <= '0;
      dp_reg <= '0;
    end else if (i_READ_BUS) begin
      value  <= bus_ext;
      dp_reg <= i_DP;
    end
  end

  scan_divider #(
    .DIVISOR (SCAN_DIVISOR)
  ) u_scan_divider (
    .clk   (i_SYS_CLOCK),
    .rst_n (i_CLEAR_n),
    .tick  (scan_tick)
  );

  assign o_SCAN_TICK = scan_tick;

  always_ff @(posedge i_SYS_CLOCK or negedge i_CLEAR_n) begin
    if (!i_CLEAR_n) begin
      state <= ST_DRIVE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Each digit gets a drive slot followed by a blank slot to suppress ghosting.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (scan_tick) begin
      case (state)
        ST_DRIVE: state_nxt = ST_BLANK;
        default: begin
          state_nxt = ST_DRIVE;
          idx_nxt   = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
      endcase
    end
  end

  // lz_mask[k]: digit k and everything above it are zero; digit 0 is never blankable.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (value[4*k +: 4] == 4'h0);
      lz_mask[k] = (k != 0) & zero_above;
    end
  end

  always_comb begin
    sel_hot  = '0;
    nibble   = '0;
    digit_dp = 1'b0;
    digit_lz = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        sel_hot[k] = 1'b1;
        nibble     = value[4*k +: 4];
        digit_dp   = dp_reg[k];
        digit_lz   = lz_mask[k];
      end
    end
  end

  always_comb begin
    sel_on = '0;
    seg_on = '0;
    dp_on  = 1'b0;
    if (state == ST_DRIVE) begin
      sel_on = sel_hot;
      if (!(i_BLANK_LZ && digit_lz)) begin
        seg_on = hex_to_seg(nibble);
        dp_on  = digit_dp;
      end
    end
  end

  // XOR with the inactive level maps logical-active onto the pin polarity.
  always_ff @(posedge i_SYS_CLOCK or negedge i_CLEAR_n) begin
    if (!i_CLEAR_n) begin
      o_SEL    <= SEL_OFF;
      o_SEG    <= SEG_OFF;
      o_SEG_DP <= DP_OFF;
    end else begin
      o_SEL    <= sel_on ^ SEL_OFF;
      o_SEG    <= seg_on ^ SEG_OFF;
      o_SEG_DP <= dp_on ^ DP_OFF;
    end
  end

endmodule
